// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE-array tile scheduler.
package pe_sched_pkg;

  localparam int unsigned DEF_TILE   = 8;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DIM_W  = 8;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned CMD_FLAG_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Words in one TILE x TILE tile.
  function automatic int unsigned tile_words(input int unsigned tile);
    return tile * tile;
  endfunction

  localparam int unsigned DEF_TILE_WORDS = DEF_TILE * DEF_TILE;

endpackage

// File: rtl/pe_tile_scheduler_if.sv
// Tile command channel between the scheduler (master) and the PE-array controller (slave).
interface pe_tile_scheduler_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_a_addr;
  logic [ADDR_W-1:0] cmd_b_addr;
  logic [ADDR_W-1:0] cmd_c_addr;
  logic              cmd_first;
  logic              cmd_last;
  logic              pe_done;

  modport master (
    output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_first, cmd_last,
    input  cmd_ready, pe_done
  );

  modport slave (
    input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_first, cmd_last,
    output cmd_ready, pe_done
  );

endinterface

// File: rtl/pe_tile_counter.sv
// Nested i/j/k tile counter with incremental A/B/C tile base pointers (no multipliers).
module pe_tile_counter
  import pe_sched_pkg::*;
#(
  parameter int unsigned TILE   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [DIM_W-1:0]  m_tiles,
  input  logic [DIM_W-1:0]  n_tiles,
  input  logic [DIM_W-1:0]  k_tiles,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] c_addr,
  output logic              first,
  output logic              last,
  output logic              wrap
);

  localparam int unsigned TW_SHIFT = $clog2(tile_words(TILE));
  localparam logic [ADDR_W-1:0] TW_STEP = ADDR_W'(tile_words(TILE));

  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic [DIM_W-1:0]  i_q, j_q, kk_q;
  logic [DIM_W-1:0]  i_n, j_n, kk_n;
  logic [DIM_W-1:0]  dim_m, dim_n, dim_k;
  logic [ADDR_W-1:0] a_stride_q, b_stride_q, b_base_q;
  logic [ADDR_W-1:0] a_row_q, b_col_q, a_row_n, b_col_n;
  logic [ADDR_W-1:0] a_q, b_q, c_q, a_n, b_n, c_n;
  logic              first_q, last_q, wrap_q;
  logic              first_n, last_n, wrap_n;

  assign dim_m = load ? m_tiles : m_q;
  assign dim_n = load ? n_tiles : n_q;
  assign dim_k = load ? k_tiles : k_q;

  // Next loop indices and pointers; flags derive from the next indices.
  always_comb begin
    i_n     = i_q;
    j_n     = j_q;
    kk_n    = kk_q;
    a_n     = a_q;
    b_n     = b_q;
    c_n     = c_q;
    a_row_n = a_row_q;
    b_col_n = b_col_q;
    if (load) begin
      i_n     = '0;
      j_n     = '0;
      kk_n    = '0;
      a_n     = a_base;
      b_n     = b_base;
      c_n     = c_base;
      a_row_n = a_base;
      b_col_n = b_base;
    end else if (advance) begin
      if (!last_q) begin
        kk_n = kk_q + DIM_W'(1);
        a_n  = a_q + TW_STEP;
        b_n  = b_q + b_stride_q;
      end else begin
        kk_n = '0;
        c_n  = c_q + TW_STEP;
        if (j_q != n_q - DIM_W'(1)) begin
          j_n     = j_q + DIM_W'(1);
          a_n     = a_row_q;
          b_col_n = b_col_q + TW_STEP;
          b_n     = b_col_q + TW_STEP;
        end else begin
          j_n     = '0;
          i_n     = i_q + DIM_W'(1);
          a_row_n = a_row_q + a_stride_q;
          a_n     = a_row_q + a_stride_q;
          b_col_n = b_base_q;
          b_n     = b_base_q;
        end
      end
    end
    first_n = (kk_n == '0);
    last_n  = (kk_n == dim_k - DIM_W'(1));
    wrap_n  = last_n && (j_n == dim_n - DIM_W'(1)) && (i_n == dim_m - DIM_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      a_stride_q <= '0;
      b_stride_q <= '0;
      b_base_q   <= '0;
    end else if (load) begin
      m_q        <= m_tiles;
      n_q        <= n_tiles;
      k_q        <= k_tiles;
      a_stride_q <= ADDR_W'(k_tiles) << TW_SHIFT;
      b_stride_q <= ADDR_W'(n_tiles) << TW_SHIFT;
      b_base_q   <= b_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q     <= '0;
      j_q     <= '0;
      kk_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      a_row_q <= '0;
      b_col_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (load || advance) begin
      i_q     <= i_n;
      j_q     <= j_n;
      kk_q    <= kk_n;
      a_q     <= a_n;
      b_q     <= b_n;
      c_q     <= c_n;
      a_row_q <= a_row_n;
      b_col_q <= b_col_n;
      first_q <= first_n;
      last_q  <= last_n;
      wrap_q  <= wrap_n;
    end
  end

  assign a_addr = a_q;
  assign b_addr = b_q;
  assign c_addr = c_q;
  assign first  = first_q;
  assign last   = last_q;
  assign wrap   = wrap_q;

endmodule

// File: rtl/pe_tile_scheduler.sv
// Issues one TILE x TILE tile command at a time for C = A x B, waiting for pe_done between tiles.
module pe_tile_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned TILE   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIM_W-1:0]   m_tiles,
  input  logic [DIM_W-1:0]   n_tiles,
  input  logic [DIM_W-1:0]   k_tiles,
  input  logic [ADDR_W-1:0]  a_base,
  input  logic [ADDR_W-1:0]  b_base,
  input  logic [ADDR_W-1:0]  c_base,
  pe_tile_scheduler_if.master cmd,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [STATE_W-1:0] IDLE  = ST_IDLE;
  localparam logic [STATE_W-1:0] ISSUE = ST_ISSUE;
  localparam logic [STATE_W-1:0] WAIT  = ST_WAIT;
  localparam logic [STATE_W-1:0] DONE  = ST_DONE;

  logic [STATE_W-1:0] state_q, state_n;
  logic               valid_q, valid_n, busy_n, done_n, err_n;
  logic               zero_dim, load, advance, wrap;
  logic [ADDR_W-1:0]  a_addr, b_addr, c_addr;
  logic               first, last;

  assign zero_dim = (m_tiles == '0) || (n_tiles == '0) || (k_tiles == '0);
  assign load     = (state_q == IDLE) && start && !zero_dim;
  assign advance  = (state_q == WAIT) && cmd.pe_done;

  pe_tile_counter #(
    .TILE   (TILE),
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .m_tiles (m_tiles),
    .n_tiles (n_tiles),
    .k_tiles (k_tiles),
    .a_base  (a_base),
    .b_base  (b_base),
    .c_base  (c_base),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .c_addr  (c_addr),
    .first   (first),
    .last    (last),
    .wrap    (wrap)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_n = state_q;
    err_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (zero_dim) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: if (cmd.cmd_ready) state_n = WAIT;
      WAIT:  if (cmd.pe_done) state_n = wrap ? DONE : ISSUE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == ISSUE);
    busy_n  = (state_n == ISSUE) || (state_n == WAIT);
    done_n  = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      valid_q <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  assign cmd.cmd_valid  = valid_q;
  assign cmd.cmd_a_addr = a_addr;
  assign cmd.cmd_b_addr = b_addr;
  assign cmd.cmd_c_addr = c_addr;
  assign cmd.cmd_first  = first;
  assign cmd.cmd_last   = last;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Directed self-checking bench for pe_tile_scheduler (TILE=8, tile = 0x40 words).
module tb_pe_tile_scheduler;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        first;
    logic        last;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  m_tiles = '0, n_tiles = '0, k_tiles = '0;
  logic [31:0] a_base = '0, b_base = '0, c_base = '0;
  logic        busy, done, err;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  rec_t cmd_q[$];

  pe_tile_scheduler_if #(.ADDR_W(32)) cmd_if ();

  pe_tile_scheduler #(.TILE(8), .ADDR_W(32), .DIM_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .m_tiles (m_tiles),
    .n_tiles (n_tiles),
    .k_tiles (k_tiles),
    .a_base  (a_base),
    .b_base  (b_base),
    .c_base  (c_base),
    .cmd     (cmd_if),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Record accepted commands and done/err pulses mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready)
        cmd_q.push_back('{a: cmd_if.cmd_a_addr, b: cmd_if.cmd_b_addr, c: cmd_if.cmd_c_addr,
                          first: cmd_if.cmd_first, last: cmd_if.cmd_last});
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    cmd_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic start_job(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                           input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb);
    m_tiles = m; n_tiles = n; k_tiles = k;
    a_base = ab; b_base = bb; c_base = cb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Acts as the PE-array controller until done; ready is delayed by 'stall' cycles.
  task automatic drive_until_done(input int stall);
    int cyc = 0;
    int w = 0;
    bit fin = 0;
    while (!fin && cyc < 400) begin
      cmd_if.cmd_ready = 1'b0;
      cmd_if.pe_done   = 1'b0;
      if (done) fin = 1;
      else begin
        if (cmd_if.cmd_valid) begin
          if (w >= stall) begin cmd_if.cmd_ready = 1'b1; w = 0; end
          else w++;
        end else if (busy) begin
          cmd_if.pe_done = 1'b1;
        end
        tick();
        cyc++;
      end
    end
    cmd_if.cmd_ready = 1'b0;
    cmd_if.pe_done   = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL job_timeout: done not seen after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_first, cmd_if.cmd_last, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {cmd_if.cmd_valid, cmd_if.cmd_first, cmd_if.cmd_last, busy, done, err});
    end
    total++;
    if ({cmd_if.cmd_a_addr, cmd_if.cmd_b_addr, cmd_if.cmd_c_addr} !== 96'b0) begin
      bad++;
      $display("FAIL reset_addr: got %h %h %h want 0", cmd_if.cmd_a_addr, cmd_if.cmd_b_addr,
               cmd_if.cmd_c_addr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    rec_t want = '{a: 32'h100, b: 32'h200, c: 32'h300, first: 1'b1, last: 1'b1};
    rec_t got;
    clear_log();
    start_job(8'd1, 8'd1, 8'd1, 32'h100, 32'h200, 32'h300);
    got = '{a: cmd_if.cmd_a_addr, b: cmd_if.cmd_b_addr, c: cmd_if.cmd_c_addr,
            first: cmd_if.cmd_first, last: cmd_if.cmd_last};
    total++;
    if ({cmd_if.cmd_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL single_start_latency: valid,busy=%b want 11", {cmd_if.cmd_valid, busy});
    end
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL single_cmd: got %h want %h", got, want);
    end
    cmd_if.cmd_ready = 1'b1; tick(); cmd_if.cmd_ready = 1'b0;
    total++;
    if ({cmd_if.cmd_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL single_handshake: valid,busy=%b want 01", {cmd_if.cmd_valid, busy});
    end
    cmd_if.pe_done = 1'b1; tick(); cmd_if.pe_done = 1'b0;
    total++;
    if ({done, err, busy, cmd_if.cmd_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL single_done: done,err,busy,valid=%b want 1000",
               {done, err, busy, cmd_if.cmd_valid});
    end
    tick();
    total++;
    if (done !== 1'b0 || done_cnt != 1 || cmd_q.size() != 1) begin
      bad++;
      $display("FAIL single_done_pulse: done=%b pulses=%0d cmds=%0d want 0 1 1",
               done, done_cnt, cmd_q.size());
    end
  endtask

  task automatic test_job_212;
    rec_t want[4];
    want[0] = '{a: 32'h1000, b: 32'h2000, c: 32'h3000, first: 1'b1, last: 1'b0};
    want[1] = '{a: 32'h1040, b: 32'h2040, c: 32'h3000, first: 1'b0, last: 1'b1};
    want[2] = '{a: 32'h1080, b: 32'h2000, c: 32'h3040, first: 1'b1, last: 1'b0};
    want[3] = '{a: 32'h10C0, b: 32'h2040, c: 32'h3040, first: 1'b0, last: 1'b1};
    clear_log();
    start_job(8'd2, 8'd1, 8'd2, 32'h1000, 32'h2000, 32'h3000);
    drive_until_done(0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL j212_err: got %b want 0", err); end
    tick();
    total++;
    if (cmd_q.size() != 4) begin
      bad++;
      $display("FAIL j212_count: got %0d want 4", cmd_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= cmd_q.size()) begin
        bad++;
        $display("FAIL j212_cmd%0d: missing want %h", i, want[i]);
      end else if (cmd_q[i] !== want[i]) begin
        bad++;
        $display("FAIL j212_cmd%0d: got %h want %h", i, cmd_q[i], want[i]);
      end
    end
  endtask

  task automatic test_job_222;
    rec_t want[8];
    want[0] = '{a: 32'h000, b: 32'h1000, c: 32'h2000, first: 1'b1, last: 1'b0};
    want[1] = '{a: 32'h040, b: 32'h1080, c: 32'h2000, first: 1'b0, last: 1'b1};
    want[2] = '{a: 32'h000, b: 32'h1040, c: 32'h2040, first: 1'b1, last: 1'b0};
    want[3] = '{a: 32'h040, b: 32'h10C0, c: 32'h2040, first: 1'b0, last: 1'b1};
    want[4] = '{a: 32'h080, b: 32'h1000, c: 32'h2080, first: 1'b1, last: 1'b0};
    want[5] = '{a: 32'h0C0, b: 32'h1080, c: 32'h2080, first: 1'b0, last: 1'b1};
    want[6] = '{a: 32'h080, b: 32'h1040, c: 32'h20C0, first: 1'b1, last: 1'b0};
    want[7] = '{a: 32'h0C0, b: 32'h10C0, c: 32'h20C0, first: 1'b0, last: 1'b1};
    clear_log();
    start_job(8'd2, 8'd2, 8'd2, 32'h0, 32'h1000, 32'h2000);
    drive_until_done(2);
    tick();
    total++;
    if (cmd_q.size() != 8 || done_cnt != 1) begin
      bad++;
      $display("FAIL j222_count: cmds=%0d pulses=%0d want 8 1", cmd_q.size(), done_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= cmd_q.size()) begin
        bad++;
        $display("FAIL j222_cmd%0d: missing want %h", i, want[i]);
      end else if (cmd_q[i] !== want[i]) begin
        bad++;
        $display("FAIL j222_cmd%0d: got %h want %h", i, cmd_q[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    rec_t want0 = '{a: 32'h100, b: 32'h200, c: 32'h300, first: 1'b1, last: 1'b1};
    rec_t want1 = '{a: 32'h100, b: 32'h240, c: 32'h340, first: 1'b1, last: 1'b1};
    rec_t got;
    clear_log();
    start_job(8'd1, 8'd2, 8'd1, 32'h100, 32'h200, 32'h300);
    for (int i = 0; i < 5; i++) begin
      got = '{a: cmd_if.cmd_a_addr, b: cmd_if.cmd_b_addr, c: cmd_if.cmd_c_addr,
              first: cmd_if.cmd_first, last: cmd_if.cmd_last};
      total++;
      if (cmd_if.cmd_valid !== 1'b1 || got !== want0) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b cmd=%h want 1 %h", i, cmd_if.cmd_valid, got, want0);
      end
      tick();
    end
    cmd_if.cmd_ready = 1'b1; tick(); cmd_if.cmd_ready = 1'b0;
    total++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: valid=%b want 0", cmd_if.cmd_valid);
    end
    tick();
    total++;
    if (cmd_q.size() != 1) begin
      bad++;
      $display("FAIL bp_one_handshake: got %0d want 1", cmd_q.size());
    end
    drive_until_done(3);
    tick();
    total++;
    if (cmd_q.size() != 2) begin
      bad++;
      $display("FAIL bp_count: got %0d want 2", cmd_q.size());
    end else if (cmd_q[1] !== want1) begin
      bad++;
      $display("FAIL bp_cmd1: got %h want %h", cmd_q[1], want1);
    end
  endtask

  task automatic test_zero_dim;
    clear_log();
    start_job(8'd3, 8'd3, 8'd0, 32'h1, 32'h2, 32'h3);
    total++;
    if ({done, err, busy, cmd_if.cmd_valid} !== 4'b1100) begin
      bad++;
      $display("FAIL zero_done_err: done,err,busy,valid=%b want 1100",
               {done, err, busy, cmd_if.cmd_valid});
    end
    tick();
    total++;
    if ({done, err} !== 2'b00) begin
      bad++;
      $display("FAIL zero_pulse_len: done,err=%b want 00", {done, err});
    end
    tick(); tick();
    total++;
    if (cmd_q.size() != 0 || done_cnt != 1 || err_cnt != 1) begin
      bad++;
      $display("FAIL zero_no_cmd: cmds=%0d dones=%0d errs=%0d want 0 1 1",
               cmd_q.size(), done_cnt, err_cnt);
    end
  endtask

  task automatic test_spurious;
    rec_t want[2];
    want[0] = '{a: 32'hFFFF_FFC0, b: 32'h5000, c: 32'h6000, first: 1'b1, last: 1'b0};
    want[1] = '{a: 32'h0000_0000, b: 32'h5040, c: 32'h6000, first: 1'b0, last: 1'b1};
    clear_log();
    start_job(8'd1, 8'd1, 8'd2, 32'hFFFF_FFC0, 32'h5000, 32'h6000);
    cmd_if.pe_done = 1'b1; tick(); cmd_if.pe_done = 1'b0;
    total++;
    if (cmd_if.cmd_valid !== 1'b1 || busy !== 1'b1 || cmd_if.cmd_a_addr !== 32'hFFFF_FFC0) begin
      bad++;
      $display("FAIL spur_done_in_issue: valid=%b busy=%b a=%h want 1 1 ffffffc0",
               cmd_if.cmd_valid, busy, cmd_if.cmd_a_addr);
    end
    cmd_if.cmd_ready = 1'b1; tick(); cmd_if.cmd_ready = 1'b0;
    start_job(8'd5, 8'd5, 8'd5, 32'hDEAD_0000, 32'hBEEF_0000, 32'hCAFE_0000);
    total++;
    if ({cmd_if.cmd_valid, busy, done} !== 3'b010) begin
      bad++;
      $display("FAIL spur_start_in_wait: valid,busy,done=%b want 010",
               {cmd_if.cmd_valid, busy, done});
    end
    drive_until_done(0);
    tick();
    total++;
    if (cmd_q.size() != 2 || done_cnt != 1) begin
      bad++;
      $display("FAIL spur_count: cmds=%0d dones=%0d want 2 1", cmd_q.size(), done_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= cmd_q.size()) begin
        bad++;
        $display("FAIL spur_cmd%0d: missing want %h", i, want[i]);
      end else if (cmd_q[i] !== want[i]) begin
        bad++;
        $display("FAIL spur_cmd%0d: got %h want %h", i, cmd_q[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_job;
    rec_t want = '{a: 32'h10, b: 32'h20, c: 32'h30, first: 1'b1, last: 1'b1};
    clear_log();
    start_job(8'd2, 8'd2, 8'd2, 32'h0, 32'h1000, 32'h2000);
    cmd_if.cmd_ready = 1'b1; tick(); cmd_if.cmd_ready = 1'b0;
    total++;
    if ({cmd_if.cmd_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL rst_pre_wait: valid,busy=%b want 01", {cmd_if.cmd_valid, busy});
    end
    reset = 1'b1; tick();
    total++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_first, cmd_if.cmd_last, busy, done, err} !== 6'b0 ||
        {cmd_if.cmd_a_addr, cmd_if.cmd_b_addr, cmd_if.cmd_c_addr} !== 96'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs: flags=%b a=%h b=%h c=%h want all 0",
               {cmd_if.cmd_valid, cmd_if.cmd_first, cmd_if.cmd_last, busy, done, err},
               cmd_if.cmd_a_addr, cmd_if.cmd_b_addr, cmd_if.cmd_c_addr);
    end
    reset = 1'b0;
    cmd_if.pe_done = 1'b1; tick(); cmd_if.pe_done = 1'b0;
    tick();
    total++;
    if ({busy, done, cmd_if.cmd_valid} !== 3'b000 || done_cnt != 0) begin
      bad++;
      $display("FAIL rst_stray_done: busy,done,valid=%b dones=%0d want 000 0",
               {busy, done, cmd_if.cmd_valid}, done_cnt);
    end
    clear_log();
    start_job(8'd1, 8'd1, 8'd1, 32'h10, 32'h20, 32'h30);
    drive_until_done(1);
    tick();
    total++;
    if (cmd_q.size() != 1 || done_cnt != 1 || err_cnt != 0) begin
      bad++;
      $display("FAIL rst_rerun_count: cmds=%0d dones=%0d errs=%0d want 1 1 0",
               cmd_q.size(), done_cnt, err_cnt);
    end else if (cmd_q[0] !== want) begin
      bad++;
      $display("FAIL rst_rerun_cmd: got %h want %h", cmd_q[0], want);
    end
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    cmd_if.pe_done   = 1'b0;
    test_reset();
    test_single();
    test_job_212();
    test_job_222();
    test_backpressure();
    test_zero_dim();
    test_spurious();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
